// File: rtl/repetition_window_ctrl.sv
// Window controller in front of a fast_repetition engine: feeds fields, waits for the rate to settle, reports per-window results.
// Optional idle-gap timeout is enabled by defining REP_WINDOW_TIMEOUT_EN.
module repetition_window_ctrl #(
    parameter int FIELD_SIZE     = 16,
    parameter int CNT_W          = 16,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      window_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FIELD_SIZE-1:0] in_field,
    output logic                  rep_valid,
    output logic                  rep_clear,
    output logic [FIELD_SIZE-1:0] rep_field,
    input  logic [FIELD_SIZE-1:0] rep_rate,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [FIELD_SIZE-1:0] res_rate,
    output logic [CNT_W-1:0]      res_count,
    output logic                  res_timeout
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   len_r;
    logic [CNT_W-1:0]   count_r;
    logic               first_r;
    logic [DRAIN_W-1:0] drain_r;
    logic               xfer_s;
    logic               last_s;
    logic               idle_hit_s;
    logic               start_win_s;
    logic               go_drain_s;
    logic               timeout_hit_s;
    logic               report_s;

    assign xfer_s = in_valid & in_ready;
    assign last_s = (count_r == (len_r - {{(CNT_W-1){1'b0}}, 1'b1}));

`ifdef REP_WINDOW_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_r;
    logic            to_r;

    assign idle_hit_s = (count_r != {CNT_W{1'b0}}) && (idle_r >= TO_W'(TIMEOUT_CYCLES - 1));

    // Idle-gap counter for the open window and the sticky timeout flag of that window.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_r <= {TO_W{1'b0}};
            to_r   <= 1'b0;
        end else begin
            if (start_win_s || xfer_s) begin
                idle_r <= {TO_W{1'b0}};
            end else if ((state_r == FEED) && (count_r != {CNT_W{1'b0}})) begin
                idle_r <= idle_r + {{(TO_W-1){1'b0}}, 1'b1};
            end else begin
                idle_r <= idle_r;
            end
            if (start_win_s) begin
                to_r <= 1'b0;
            end else if (timeout_hit_s) begin
                to_r <= 1'b1;
            end else begin
                to_r <= to_r;
            end
        end
    end
`else
    assign idle_hit_s = 1'b0;
`endif

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_s       = state_r;
        start_win_s   = 1'b0;
        go_drain_s    = 1'b0;
        timeout_hit_s = 1'b0;
        report_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s     = FEED;
                    start_win_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            FEED: begin
                // An accepted field always counts, so enable dropping alongside it still yields a report.
                if (xfer_s) begin
                    if (last_s || !enable) begin
                        state_s    = DRAIN;
                        go_drain_s = 1'b1;
                    end else begin
                        state_s = FEED;
                    end
                end else if (!enable) begin
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_s = IDLE;
                    end else begin
                        state_s    = DRAIN;
                        go_drain_s = 1'b1;
                    end
                end else if (idle_hit_s) begin
                    state_s       = DRAIN;
                    go_drain_s    = 1'b1;
                    timeout_hit_s = 1'b1;
                end else begin
                    state_s = FEED;
                end
            end
            DRAIN: begin
                if (drain_r == {DRAIN_W{1'b0}}) begin
                    state_s  = REPORT;
                    report_s = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    if (enable) begin
                        state_s     = FEED;
                        start_win_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = REPORT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and the registered in_ready that mirrors FEED.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state_r  <= state_s;
            in_ready <= (state_s == FEED);
        end
    end

    // Window bookkeeping: latched length, saturating field count, first-field flag, drain timer.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r   <= {CNT_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            first_r <= 1'b1;
            drain_r <= {DRAIN_W{1'b0}};
        end else begin
            if (start_win_s) begin
                len_r   <= (window_len == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : window_len;
                count_r <= {CNT_W{1'b0}};
                first_r <= 1'b1;
            end else if (xfer_s) begin
                count_r <= (count_r == {CNT_W{1'b1}}) ? count_r : count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                first_r <= 1'b0;
            end else begin
                count_r <= count_r;
                first_r <= first_r;
            end
            if (go_drain_s) begin
                drain_r <= DRAIN_W'(DRAIN_CYCLES);
            end else if ((state_r == DRAIN) && (drain_r != {DRAIN_W{1'b0}})) begin
                drain_r <= drain_r - {{(DRAIN_W-1){1'b0}}, 1'b1};
            end else begin
                drain_r <= drain_r;
            end
        end
    end

    // Registered repetition-engine drive and result holding registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_valid   <= 1'b0;
            rep_clear   <= 1'b0;
            rep_field   <= {FIELD_SIZE{1'b0}};
            res_valid   <= 1'b0;
            res_rate    <= {FIELD_SIZE{1'b0}};
            res_count   <= {CNT_W{1'b0}};
            res_timeout <= 1'b0;
        end else begin
            rep_valid <= xfer_s;
            rep_clear <= xfer_s & first_r;
            if (xfer_s) begin
                rep_field <= in_field;
            end else begin
                rep_field <= rep_field;
            end
            if (report_s) begin
                res_valid   <= 1'b1;
                res_rate    <= rep_rate;
                res_count   <= count_r;
`ifdef REP_WINDOW_TIMEOUT_EN
                res_timeout <= to_r;
`else
                res_timeout <= 1'b0;
`endif
            end else if ((state_r == REPORT) && res_ready) begin
                res_valid <= 1'b0;
            end else begin
                res_valid <= res_valid;
            end
        end
    end

endmodule

// File: tb/tb_repetition_window_ctrl.sv
// Self-checking bench for repetition_window_ctrl: directed scenarios plus randomized windows against a window-level model.
module tb_repetition_window_ctrl;

    localparam int FS = 16;
    localparam int CW = 16;
    localparam int DC = 4;
    localparam int TC = 16;

    logic          sys_clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] window_len;
    logic          in_valid;
    logic          in_ready;
    logic [FS-1:0] in_field;
    logic          rep_valid;
    logic          rep_clear;
    logic [FS-1:0] rep_field;
    logic [FS-1:0] rep_rate;
    logic          res_valid;
    logic          res_ready;
    logic [FS-1:0] res_rate;
    logic [CW-1:0] res_count;
    logic          res_timeout;

    int checks = 0;
    int errors = 0;
    bit first_exp;
    int wcount;

    repetition_window_ctrl #(
        .FIELD_SIZE(FS), .CNT_W(CW), .DRAIN_CYCLES(DC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .window_len(window_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_field(in_field),
        .rep_valid(rep_valid), .rep_clear(rep_clear), .rep_field(rep_field),
        .rep_rate(rep_rate), .res_valid(res_valid), .res_ready(res_ready),
        .res_rate(res_rate), .res_count(res_count), .res_timeout(res_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_rep_valid"}, rep_valid, 1'b0);
        chk({tag, "_rep_clear"}, rep_clear, 1'b0);
        chk({tag, "_rep_field"}, rep_field, 16'd0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_rate"}, res_rate, 16'd0);
        chk({tag, "_res_count"}, res_count, 16'd0);
        chk({tag, "_res_timeout"}, res_timeout, 1'b0);
    endtask

    // Offer one field, wait (bounded) for acceptance, then check the forwarded copy.
    task automatic send(input logic [FS-1:0] f);
        bit ok = 1'b0;
        bit rdy;
        in_valid = 1'b1;
        in_field = f;
        for (int i = 0; i < 30 && !ok; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            chk("accept_wait", 32'd0, 32'd1);
        end else begin
            chk("rep_valid", rep_valid, 1'b1);
            chk("rep_field", rep_field, f);
            chk("rep_clear", rep_clear, first_exp);
            first_exp = 1'b0;
            wcount++;
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("gap_rep_valid", rep_valid, 1'b0);
            chk("gap_rep_clear", rep_clear, 1'b0);
        end
    endtask

    // Expect one window result; optionally verify it does not appear before the settle time.
    task automatic expect_report(input int cnt, input logic [FS-1:0] rate, input bit to,
                                 input bit early, input int hold);
        bit got = 1'b0;
        if (early) begin
            for (int i = 0; i < DC; i++) begin
                tick();
                chk("res_early", res_valid, 1'b0);
                chk("ready_drain", in_ready, 1'b0);
                chk("drain_rep_valid", rep_valid, 1'b0);
            end
        end
        for (int i = 0; i < DC + TC + 20 && !got; i++) begin
            if (res_valid) got = 1'b1;
            else tick();
        end
        if (!got) begin
            chk("res_wait", 32'd0, 32'd1);
        end else begin
            chk("res_count", res_count, cnt);
            chk("res_rate", res_rate, rate);
            chk("res_timeout", res_timeout, to);
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_res_valid", res_valid, 1'b1);
                chk("hold_res_count", res_count, cnt);
                chk("hold_res_rate", res_rate, rate);
                chk("hold_in_ready", in_ready, 1'b0);
            end
        end
    endtask

    task automatic ack(input bit en_after);
        res_ready = 1'b1;
        enable    = en_after;
        tick();
        res_ready = 1'b0;
        chk("ack_res_valid", res_valid, 1'b0);
        chk("ack_in_ready", in_ready, en_after);
        first_exp = 1'b1;
        wcount    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int            len;
        int            n;
        logic [FS-1:0] rate;
        reset_n    = 1'b0;
        enable     = 1'b0;
        window_len = 16'd0;
        in_valid   = 1'b0;
        in_field   = 16'd0;
        rep_rate   = 16'd0;
        res_ready  = 1'b0;
        first_exp  = 1'b1;
        wcount     = 0;
        #12;
        check_all_zero("reset");
        #11;
        reset_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1'b0);

        // Four-field window with a back-pressured result, then a back-to-back window.
        window_len = 16'd4;
        rep_rate   = 16'd3;
        enable     = 1'b1;
        tick();
        chk("feed_in_ready", in_ready, 1'b1);
        send(16'd5); send(16'd5); send(16'd5); send(16'd7);
        expect_report(4, 16'd3, 1'b0, 1'b1, 10);
        window_len = 16'd4;
        ack(1'b1);
        rep_rate = 16'd9;
        send(16'd9); send(16'd1); gap(2); send(16'd2); send(16'd3);
        expect_report(4, 16'd9, 1'b0, 1'b1, 0);
        ack(1'b0);

        // Partial window closed by enable going low.
        window_len = 16'd8;
        rep_rate   = 16'd6;
        enable     = 1'b1;
        tick();
        send(16'h11); gap(1); send(16'h22); send(16'h33);
        enable = 1'b0;
        tick();
        expect_report(3, 16'd6, 1'b0, 1'b1, 2);
        ack(1'b0);
        gap(3);
        chk("idle_after_partial", in_ready, 1'b0);

        // Enable pulse with no fields: no result at all.
        window_len = 16'd5;
        enable     = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        chk("empty_in_ready", in_ready, 1'b0);
        for (int i = 0; i < DC + 4; i++) begin
            tick();
            chk("empty_no_res", res_valid, 1'b0);
        end

        // Zero length: each field is its own window.
        window_len = 16'd0;
        rep_rate   = 16'd2;
        enable     = 1'b1;
        tick();
        send(16'hA0);
        expect_report(1, 16'd2, 1'b0, 1'b1, 0);
        window_len = 16'd0;
        ack(1'b1);
        send(16'hA1);
        expect_report(1, 16'd2, 1'b0, 1'b1, 1);
        ack(1'b0);

        // Randomized windows.
        for (int w = 0; w < 12; w++) begin
            len        = $urandom_range(0, 6);
            rate       = FS'($urandom);
            window_len = CW'(len);
            rep_rate   = rate;
            enable     = 1'b1;
            tick();
            chk("rnd_in_ready", in_ready, 1'b1);
            n = (len == 0) ? 1 : len;
            for (int j = 0; j < n; j++) begin
                send(FS'($urandom));
                if (j != n - 1) gap($urandom_range(0, 3));
            end
            expect_report(wcount, rate, 1'b0, 1'b1, $urandom_range(0, 5));
            ack(1'b0);
        end

        // Reset in the middle of a window.
        window_len = 16'd8;
        rep_rate   = 16'd4;
        enable     = 1'b1;
        tick();
        send(16'h55); send(16'h66);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        #10;
        reset_n    = 1'b1;
        first_exp  = 1'b1;
        wcount     = 0;
        window_len = 16'd2;
        tick();
        send(16'h77); send(16'h88);
        expect_report(2, 16'd4, 1'b0, 1'b1, 0);
        ack(1'b0);

        // Long idle gap inside a window.
        window_len = 16'd8;
        rep_rate   = 16'd12;
        enable     = 1'b1;
        tick();
        send(16'h1); send(16'h2);
`ifdef REP_WINDOW_TIMEOUT_EN
        expect_report(2, 16'd12, 1'b1, 1'b0, 0);
        ack(1'b0);
`else
        for (int i = 0; i < TC + DC + 20; i++) begin
            tick();
            chk("notimeout_in_ready", in_ready, 1'b1);
            chk("notimeout_res_valid", res_valid, 1'b0);
        end
        enable = 1'b0;
        tick();
        expect_report(2, 16'd12, 1'b0, 1'b1, 0);
        ack(1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
